// File: rtl/inst_queue.sv
// inst_queue: in-order circular buffer between fetch and the two decoders.
// Takes up to two fetched instructions per cycle. Presents the two oldest
// entries to decode and retires zero, one or two of them per cycle.
// A redirect flush empties the queue in a single cycle.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [1:0]  in_valid,
   input  logic [31:0] in_pc0,
   input  logic [31:0] in_pc1,
   input  logic [31:0] in_inst0,
   input  logic [31:0] in_inst1,
   input  logic        in_exc0,
   input  logic        in_exc1,
   input  logic [6:0]  in_exc_cause0,
   input  logic [6:0]  in_exc_cause1,
   output logic        in_ready,
   output logic [1:0]  out_valid,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1,
   output logic [31:0] out_inst0,
   output logic [31:0] out_inst1,
   output logic        out_exc0,
   output logic        out_exc1,
   output logic [6:0]  out_exc_cause0,
   output logic [6:0]  out_exc_cause1,
   input  logic [1:0]  out_pop
);

   localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
   localparam logic [PTR_W:0] TWO       = (PTR_W+1)'(2);

   // Entry storage, split by field
   logic [31:0]      r_pcMem    [DEPTH];
   logic [31:0]      r_instMem  [DEPTH];
   logic             r_excMem   [DEPTH];
   logic [6:0]       r_causeMem [DEPTH];

   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;

   logic             w_valid0;
   logic             w_valid1;
   logic             w_push0;
   logic             w_push1;
   logic             w_pop0;
   logic             w_pop1;
   logic [1:0]       w_pushCnt;
   logic [1:0]       w_popCnt;
   logic [PTR_W-1:0] w_wrIdx1;
   logic [PTR_W-1:0] w_rdIdx1;

   // Readiness comes only from the registered count, so fetch never sees a
   // combinational path from decode's pop or from its own valids.
   assign in_ready  = (r_count <= READY_MAX);
   assign w_valid0  = (r_count != '0);
   assign w_valid1  = (r_count >= TWO);
   assign out_valid = {w_valid1, w_valid0};

   // Slot 1 lands right after slot 0 only when slot 0 actually wrote.
   assign w_push0   = in_ready & in_valid[0];
   assign w_push1   = in_ready & in_valid[1];
   assign w_pushCnt = {1'b0, w_push0} + {1'b0, w_push1};
   assign w_wrIdx1  = r_wrPtr + PTR_W'(in_valid[0]);

   // Pops are masked to the legal in-order subset of what is presented.
   assign w_pop0    = out_pop[0] & w_valid0;
   assign w_pop1    = out_pop[1] & w_pop0 & w_valid1;
   assign w_popCnt  = {1'b0, w_pop0} + {1'b0, w_pop1};
   assign w_rdIdx1  = r_rdPtr + PTR_W'(1);

   // Head slots are read straight out of storage and forced to zero when empty.
   assign out_pc0        = w_valid0 ? r_pcMem[r_rdPtr]     : '0;
   assign out_inst0      = w_valid0 ? r_instMem[r_rdPtr]   : '0;
   assign out_exc0       = w_valid0 ? r_excMem[r_rdPtr]    : 1'b0;
   assign out_exc_cause0 = w_valid0 ? r_causeMem[r_rdPtr]  : '0;
   assign out_pc1        = w_valid1 ? r_pcMem[w_rdIdx1]    : '0;
   assign out_inst1      = w_valid1 ? r_instMem[w_rdIdx1]  : '0;
   assign out_exc1       = w_valid1 ? r_excMem[w_rdIdx1]   : 1'b0;
   assign out_exc_cause1 = w_valid1 ? r_causeMem[w_rdIdx1] : '0;

   // Write accepted fetch slots into storage; a flush cycle discards them
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (w_push0) begin
            r_pcMem[r_wrPtr]    <= in_pc0;
            r_instMem[r_wrPtr]  <= in_inst0;
            r_excMem[r_wrPtr]   <= in_exc0;
            r_causeMem[r_wrPtr] <= in_exc_cause0;
         end
         if (w_push1) begin
            r_pcMem[w_wrIdx1]    <= in_pc1;
            r_instMem[w_wrIdx1]  <= in_inst1;
            r_excMem[w_wrIdx1]   <= in_exc1;
            r_causeMem[w_wrIdx1] <= in_exc_cause1;
         end
      end
   end

   // Advance pointers and occupancy; flush outranks both push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         r_wrPtr <= r_wrPtr + PTR_W'(w_pushCnt);
         r_rdPtr <= r_rdPtr + PTR_W'(w_popCnt);
         r_count <= r_count + (PTR_W+1)'(w_pushCnt) - (PTR_W+1)'(w_popCnt);
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed vectors, with a queue model acting as
// the scoreboard and an independent monitor comparing every cycle.
module tb_inst_queue;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
      logic [6:0]  cause;
   } entry_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [1:0]  in_valid;
   logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
   logic        in_exc0, in_exc1;
   logic [6:0]  in_exc_cause0, in_exc_cause1;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
   logic        out_exc0, out_exc1;
   logic [6:0]  out_exc_cause0, out_exc_cause1;
   logic [1:0]  out_pop;

   entry_t      expQ[$];
   entry_t      pendQ[$];
   entry_t      popped;
   entry_t      exp0, exp1, got0, got1;
   int          monSize;
   int          popSize;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] nextPc;
   logic [31:0] firstPc;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
      .in_exc0(in_exc0), .in_exc1(in_exc1),
      .in_exc_cause0(in_exc_cause0), .in_exc_cause1(in_exc_cause1),
      .in_ready(in_ready), .out_valid(out_valid),
      .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
      .out_exc0(out_exc0), .out_exc1(out_exc1),
      .out_exc_cause0(out_exc_cause0), .out_exc_cause1(out_exc_cause1),
      .out_pop(out_pop)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic entry_t mkEntry(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic exc, input logic [6:0] cause);
      entry_t e;
      e.pc    = pc;
      e.inst  = inst;
      e.exc   = exc;
      e.cause = cause;
      return e;
   endfunction

   // Drive one cycle of inputs; accepted entries go to the pending list until the edge
   task automatic applyStimulus(input logic [1:0] v, input entry_t e0, input entry_t e1,
                                input logic [1:0] pop, input logic fl);
      in_valid      = v;
      in_pc0        = e0.pc;
      in_inst0      = e0.inst;
      in_exc0       = e0.exc;
      in_exc_cause0 = e0.cause;
      in_pc1        = e1.pc;
      in_inst1      = e1.inst;
      in_exc1       = e1.exc;
      in_exc_cause1 = e1.cause;
      out_pop       = pop;
      flush         = fl;
      if (rst_n && !fl && expQ.size() <= DEPTH - 2) begin
         if (v[0]) pendQ.push_back(e0);
         if (v[1]) pendQ.push_back(e1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pushPair(input logic [1:0] pop);
      logic [31:0] pcB;
      pcB = nextPc + 32'd4;
      applyStimulus(2'b11, mkEntry(nextPc, ~nextPc, nextPc[3], nextPc[10:4]),
                    mkEntry(pcB, ~pcB, pcB[3], pcB[10:4]), pop, 1'b0);
      nextPc = nextPc + 32'd8;
   endtask

   task automatic pushOne();
      applyStimulus(2'b01, mkEntry(nextPc, ~nextPc, nextPc[3], nextPc[10:4]), '0, 2'b00, 1'b0);
      nextPc = nextPc + 32'd4;
   endtask

   // Scoreboard commit at each edge: flush empties, legal pops retire, pending pushes land
   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) begin
            expQ.delete();
            pendQ.delete();
         end else begin
            popSize = expQ.size();
            if (out_pop[0] && popSize >= 1) begin
               popped = expQ.pop_front();
               if (out_pop[1] && popSize >= 2) popped = expQ.pop_front();
            end
            while (pendQ.size() > 0) expQ.push_back(pendQ.pop_front());
         end
      end
   end

   // Monitor on the falling edge: compare presented head slots and readiness with the model
   always @(negedge clk) begin
      monSize = expQ.size();
      exp0 = (monSize >= 1) ? expQ[0] : '0;
      exp1 = (monSize >= 2) ? expQ[1] : '0;
      got0 = {out_pc0, out_inst0, out_exc0, out_exc_cause0};
      got1 = {out_pc1, out_inst1, out_exc1, out_exc_cause1};
      checkOutput("mon out_valid", 72'(out_valid), {70'd0, monSize >= 2, monSize >= 1});
      checkOutput("mon in_ready", 72'(in_ready), {71'd0, monSize <= DEPTH - 2});
      checkOutput("mon slot0", 72'(got0), 72'(exp0));
      checkOutput("mon slot1", 72'(got1), 72'(exp1));
   end

   // Directed sequence
   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = '0;
      in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
      in_exc0 = 1'b0; in_exc1 = 1'b0; in_exc_cause0 = '0; in_exc_cause1 = '0;
      out_pop = '0;
      nextPc = 32'h1c001000;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", 72'(out_valid), 72'h0);
      checkOutput("reset in_ready", 72'(in_ready), 72'h1);
      checkOutput("reset out_pc0", 72'(out_pc0), 72'h0);
      rst_n = 1'b1;

      // Single stream, slot 0 twice, nothing popped
      applyStimulus(2'b01, mkEntry(32'h1c000000, 32'h58000c85, 1'b0, 7'h0), '0, 2'b00, 1'b0);
      checkOutput("stream first valid", 72'(out_valid), 72'h1);
      applyStimulus(2'b01, mkEntry(32'h1c000004, 32'h4c000020, 1'b0, 7'h0), '0, 2'b00, 1'b0);
      checkOutput("stream out_valid", 72'(out_valid), 72'h3);
      checkOutput("stream out_pc0", 72'(out_pc0), 72'h1c000000);
      checkOutput("stream out_pc1", 72'(out_pc1), 72'h1c000004);
      checkOutput("stream out_inst1", 72'(out_inst1), 72'h4c000020);

      // Pop bit1 without bit0 is ignored, then drain both
      applyStimulus(2'b00, '0, '0, 2'b10, 1'b0);
      checkOutput("illegal pop masked", 72'(out_valid), 72'h3);
      applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
      checkOutput("drain empty", 72'(out_valid), 72'h0);

      // Exception tag passes through and retires with its entry
      applyStimulus(2'b11, mkEntry(32'h1c000010, 32'h02800000, 1'b1, 7'h08),
                    mkEntry(32'h1c000014, 32'h02800001, 1'b0, 7'h00), 2'b00, 1'b0);
      checkOutput("exc head flag", 72'(out_exc0), 72'h1);
      checkOutput("exc head cause", 72'(out_exc_cause0), 72'h08);
      applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
      checkOutput("partial pop pc0", 72'(out_pc0), 72'h1c000014);
      checkOutput("partial pop exc0", 72'(out_exc0), 72'h0);
      checkOutput("partial pop valid", 72'(out_valid), 72'h1);
      applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
      checkOutput("overpop masked", 72'(out_valid), 72'h0);

      // Fill: 14 entries still ready, 16 not, further pushes ignored
      repeat (7) pushPair(2'b00);
      checkOutput("fill 14 in_ready", 72'(in_ready), 72'h1);
      pushPair(2'b00);
      checkOutput("fill 16 in_ready", 72'(in_ready), 72'h0);
      repeat (3) pushPair(2'b00);
      checkOutput("full hold in_ready", 72'(in_ready), 72'h0);
      checkOutput("full hold valid", 72'(out_valid), 72'h3);

      // Drain to 6, then flush against simultaneous push and pop
      repeat (5) applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
      checkOutput("count6 in_ready", 72'(in_ready), 72'h1);
      applyStimulus(2'b11, mkEntry(32'h1c00f000, 32'h1, 1'b0, 7'h0),
                    mkEntry(32'h1c00f004, 32'h2, 1'b0, 7'h0), 2'b11, 1'b1);
      checkOutput("flush out_valid", 72'(out_valid), 72'h0);
      checkOutput("flush in_ready", 72'(in_ready), 72'h1);
      applyStimulus(2'b01, mkEntry(32'h1c002000, 32'h03400000, 1'b0, 7'h0), '0, 2'b00, 1'b0);
      checkOutput("post flush valid", 72'(out_valid), 72'h1);
      checkOutput("post flush pc0", 72'(out_pc0), 72'h1c002000);
      applyStimulus(2'b00, '0, '0, 2'b00, 1'b1);

      // Count 15: not ready, and a pop that cycle does not open it
      repeat (7) pushPair(2'b00);
      pushOne();
      checkOutput("count15 in_ready", 72'(in_ready), 72'h0);
      pushPair(2'b11);
      checkOutput("count13 in_ready", 72'(in_ready), 72'h1);

      // Walk the read pointer to 15 with the queue empty
      repeat (6) applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
      applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
      checkOutput("wrap setup empty", 72'(out_valid), 72'h0);

      // Push straddling indices 15/0, then push and pop straddling together
      pushPair(2'b00);
      checkOutput("wrap push valid", 72'(out_valid), 72'h3);
      firstPc = nextPc;
      pushPair(2'b11);
      checkOutput("wrap swap valid", 72'(out_valid), 72'h3);
      checkOutput("wrap swap pc0", 72'(out_pc0), 72'(firstPc));
      checkOutput("wrap swap pc1", 72'(out_pc1), 72'(firstPc + 32'd4));

      // Asynchronous reset in the middle of a cycle with 5 entries
      pushPair(2'b00);
      pushOne();
      #2;
      rst_n = 1'b0;
      expQ.delete();
      pendQ.delete();
      #1;
      checkOutput("async reset valid", 72'(out_valid), 72'h0);
      checkOutput("async reset in_ready", 72'(in_ready), 72'h1);
      checkOutput("async reset pc0", 72'(out_pc0), 72'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(2'b01, mkEntry(32'h1c003000, 32'h00100000, 1'b0, 7'h0), '0, 2'b00, 1'b0);
      checkOutput("after reset pc0", 72'(out_pc0), 72'h1c003000);
      applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
      checkOutput("final empty", 72'(out_valid), 72'h0);
      applyStimulus(2'b00, '0, '0, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
